vmem_rd_arb: RTL and testbench

Shares the single combinational-read port of the vector memory among `NREQ` requesters. Each requester issues a one-shot read with a valid/ready handshake. The arbiter registers the winning address, holds it on the memory port for one cycle, captures the returned data, and routes a one-cycle response back to the winner. It sits between the vector-pipe load units and the memory's A read port, and sustains one read per cycle under back-to-back load.

---
 rtl/vmem_rd_arb.sv | 88 ++++++++
 tb/tb_vmem_rd_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vmem_rd_arb.sv
// Arbitrated read port for the vector memory: NREQ one-shot requesters share one combinational read port.
// Define VMEM_RD_ARB_RR_EN for round-robin grant; default build is fixed priority (lowest index wins).
module vmem_rd_arb #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 8
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic [AW-1:0]      mem_a_raddr,
  output logic               mem_a_ren,
  input  logic [DW-1:0]      mem_a_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, SEND_READ} state_t;

  state_t                   state, state_d;
  logic [NREQ-1:0][AW-1:0]  addr;
  logic [PW-1:0]            gnt, owner, idx;
  logic                     accept;

  assign addr      = req_addr;
  assign mem_a_ren = (state == SEND_READ);

`ifdef VMEM_RD_ARB_RR_EN
  logic [PW-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst)         ptr <= '0;
    else if (accept) ptr <= (gnt == PW'(NREQ-1)) ? '0 : gnt + PW'(1);
  end
`endif

  // First valid requester in search order wins; grant is offered in both states.
  always_comb begin
    gnt       = '0;
    idx       = '0;
    accept    = 1'b0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef VMEM_RD_ARB_RR_EN
      idx = PW'((int'(ptr) + k) % NREQ);
`else
      idx = PW'(k);
`endif
      if (!accept && req_valid[idx]) begin
        accept = 1'b1;
        gnt    = idx;
      end
    end
    if (accept) req_ready = NREQ'(1) << gnt;
    state_d = accept ? SEND_READ : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // A new accept may land in the same cycle a response completes; they use separate registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_a_raddr <= '0;
      owner       <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
    end else begin
      if (accept) begin
        mem_a_raddr <= addr[gnt];
        owner       <= gnt;
      end
      if (state == SEND_READ) begin
        rsp_data  <= mem_a_rdata;
        rsp_valid <= NREQ'(1) << owner;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vmem_rd_arb.sv
// Bench for vmem_rd_arb: directed scenarios plus random traffic against a grant/response scoreboard.
module tb_vmem_rd_arb;
  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ-1:0][AW-1:0] addrs = '0;
  logic [NREQ-1:0]         req_ready, rsp_valid;
  logic [DW-1:0]           rsp_data, mem_a_rdata;
  logic [AW-1:0]           mem_a_raddr;
  logic                    mem_a_ren;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vmem_rd_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(addrs),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_a_raddr(mem_a_raddr), .mem_a_ren(mem_a_ren), .mem_a_rdata(mem_a_rdata)
  );

  function automatic logic [DW-1:0] memf(logic [AW-1:0] a);
    return a[7:0] ^ a[31:24] ^ 8'hE5;
  endfunction

  assign mem_a_rdata = memf(mem_a_raddr);

  // Reference model: grant search plus a queue of outstanding responses with due cycle.
  typedef struct { int owner; logic [DW-1:0] data; int due; } rsp_t;
  rsp_t            q[$];
  int              cyc = 0;
  int              m_ptr = 0;
  logic            m_ren = 1'b0;
  logic [AW-1:0]   m_raddr = '0;
  logic [NREQ-1:0] m_rv = '0;
  logic [DW-1:0]   m_rd = '0;

  function automatic int exp_grant(logic [NREQ-1:0] v, int p);
    for (int k = 0; k < NREQ; k++) begin
`ifdef VMEM_RD_ARB_RR_EN
      int i = (p + k) % NREQ;
`else
      int i = k;
`endif
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready(logic [NREQ-1:0] v);
    int g = exp_grant(v, m_ptr);
    if (g < 0) return '0;
    return NREQ'(1) << g;
  endfunction

  task automatic tick();
    int g;
    g = exp_grant(req_valid, m_ptr);
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      m_ptr = 0; m_ren = 0; m_raddr = '0; m_rv = '0; m_rd = '0;
    end else begin
      m_rv = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        m_rv = NREQ'(1) << q[0].owner;
        m_rd = q[0].data;
        void'(q.pop_front());
      end
      m_ren = (g >= 0);
      if (g >= 0) begin
        m_raddr = addrs[g];
        q.push_back('{g, memf(addrs[g]), cyc + 1});
        m_ptr = (g + 1) % NREQ;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_a_ren !== 1'b0) begin errors++; $display("FAIL reset_ren got %b exp 0", mem_a_ren); end
    checks++; if (mem_a_raddr !== '0) begin errors++; $display("FAIL reset_raddr got %h exp 0", mem_a_raddr); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_idle_ready got %b exp 0", req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    addrs[2] = 32'h40; req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    tick(); req_valid = '0;
    checks++; if (mem_a_ren !== 1'b1 || mem_a_raddr !== 32'h40) begin errors++; $display("FAIL single_port got ren=%b addr=%h exp ren=1 addr=40", mem_a_ren, mem_a_raddr); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL single_early_rsp got %b exp 0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 4'b0100 || rsp_data !== 8'hA5) begin errors++; $display("FAIL single_rsp got %b/%h exp 0100/a5", rsp_valid, rsp_data); end
    checks++; if (mem_a_ren !== 1'b0) begin errors++; $display("FAIL single_idle got ren=%b exp 0", mem_a_ren); end
    tick();
    checks++; if (rsp_valid !== '0 || rsp_data !== 8'hA5) begin errors++; $display("FAIL single_after got %b/%h exp 0000/a5", rsp_valid, rsp_data); end
  endtask

  task automatic test_all_four();
    int order [6];
`ifdef VMEM_RD_ARB_RR_EN
    order = '{0, 1, 2, 3, 0, 1};
`else
    order = '{0, 0, 0, 0, 0, 0};
`endif
    do_reset();
    for (int i = 0; i < NREQ; i++) addrs[i] = 32'h100 + 32'(i * 7);
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (req_ready !== NREQ'(1) << order[c]) begin errors++; $display("FAIL all4_grant c=%0d got %b exp req %0d", c, req_ready, order[c]); end
      tick();
      checks++; if (mem_a_ren !== 1'b1 || mem_a_raddr !== addrs[order[c]]) begin errors++; $display("FAIL all4_port c=%0d got %b/%h", c, mem_a_ren, mem_a_raddr); end
      if (c > 0) begin
        checks++; if (rsp_valid !== NREQ'(1) << order[c-1] || rsp_data !== memf(addrs[order[c-1]])) begin errors++; $display("FAIL all4_rsp c=%0d got %b/%h exp req %0d", c, rsp_valid, rsp_data, order[c-1]); end
      end
    end
    req_valid = '0; tick(); tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    addrs[0] = 32'h10; req_valid = 4'b0001;
    tick();
    addrs[0] = 32'h11;
    tick(); req_valid = '0;
    checks++; if (rsp_valid !== 4'b0001 || rsp_data !== 8'hF5) begin errors++; $display("FAIL b2b_first got %b/%h exp 0001/f5", rsp_valid, rsp_data); end
    checks++; if (mem_a_ren !== 1'b1 || mem_a_raddr !== 32'h11) begin errors++; $display("FAIL b2b_port got %b/%h exp 1/11", mem_a_ren, mem_a_raddr); end
    tick();
    checks++; if (rsp_valid !== 4'b0001 || rsp_data !== 8'hF4) begin errors++; $display("FAIL b2b_second got %b/%h exp 0001/f4", rsp_valid, rsp_data); end
    tick();
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL b2b_end got %b exp 0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    addrs[1] = 32'h2233; req_valid = 4'b0010;
    tick(); req_valid = '0; rst = 1'b1;
    tick();
    checks++; if (rsp_valid !== '0 || rsp_data !== '0 || mem_a_ren !== 1'b0 || mem_a_raddr !== '0) begin errors++; $display("FAIL rstmid_outputs got %b/%h/%b/%h exp all 0", rsp_valid, rsp_data, mem_a_ren, mem_a_raddr); end
    rst = 1'b0;
    tick();
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL rstmid_dropped got %b exp 0", rsp_valid); end
    addrs[3] = 32'h77; req_valid = 4'b1000; #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rstmid_grant got %b exp 1000", req_ready); end
    tick(); req_valid = '0; tick();
    checks++; if (rsp_valid !== 4'b1000 || rsp_data !== memf(32'h77)) begin errors++; $display("FAIL rstmid_rsp got %b/%h", rsp_valid, rsp_data); end
  endtask

  task automatic test_wrap();
    logic [NREQ-1:0] e3;
`ifdef VMEM_RD_ARB_RR_EN
    e3 = 4'b1000;
`else
    e3 = 4'b0001;
`endif
    do_reset();
    addrs[0] = 32'h5; addrs[3] = 32'h9;
    req_valid = 4'b1000; #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_first got %b exp 1000", req_ready); end
    tick(); req_valid = 4'b1001; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_zero got %b exp 0001", req_ready); end
    tick(); #1;
    checks++; if (req_ready !== e3) begin errors++; $display("FAIL wrap_next got %b exp %b", req_ready, e3); end
    req_valid = '0; tick(); tick();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] e;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom());
      for (int i = 0; i < NREQ; i++) addrs[i] = $urandom();
      rst = ($urandom_range(0, 39) == 0);
      #1;
      e = exp_ready(req_valid);
      if (!rst) begin
        checks++; if (req_ready !== e) begin errors++; $display("FAIL rand_ready c=%0d got %b exp %b", c, req_ready, e); end
      end
      tick();
      checks++; if (mem_a_ren !== m_ren || mem_a_raddr !== m_raddr) begin errors++; $display("FAIL rand_port c=%0d got %b/%h exp %b/%h", c, mem_a_ren, mem_a_raddr, m_ren, m_raddr); end
      checks++; if (rsp_valid !== m_rv || rsp_data !== m_rd) begin errors++; $display("FAIL rand_rsp c=%0d got %b/%h exp %b/%h", c, rsp_valid, rsp_data, m_rv, m_rd); end
    end
    rst = 1'b0; req_valid = '0;
  endtask

  initial begin
    tick();
    test_reset();
    test_single();
    test_all_four();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
